// File: rtl/manycore_endpoint_codec.sv
// Manycore tile network endpoint: a receive FIFO whose head is decoded into
// remote-store / freeze / unfreeze commands, and a zero-latency encoder for core stores.
module manycore_endpoint_codec #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int fifo_els_p     = 4,
  localparam int M = data_width_p / 8,
  localparam int P = 2 + M + addr_width_p + data_width_p
                     + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [P-1:0]              data_i,
  output logic                      ready_o,
  input  logic                      yumi_i,
  output logic                      pkt_v_o,
  output logic                      pkt_remote_store_o,
  output logic                      pkt_freeze_o,
  output logic                      pkt_unfreeze_o,
  output logic                      pkt_unknown_o,
  output logic [data_width_p-1:0]   store_data_o,
  output logic [addr_width_p-1:0]   store_addr_o,
  output logic [M-1:0]              store_mask_o,
  output logic [x_cord_width_p-1:0] from_x_cord_o,
  output logic [y_cord_width_p-1:0] from_y_cord_o,
  input  logic                      enc_v_i,
  input  logic                      enc_we_i,
  input  logic [addr_width_p-1:0]   enc_addr_i,
  input  logic [data_width_p-1:0]   enc_data_i,
  input  logic [M-1:0]              enc_mask_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  output logic                      v_o,
  output logic [P-1:0]              data_o,
  output logic                      ret_store_cntr_o
);

  localparam int X  = x_cord_width_p;
  localparam int Y  = y_cord_width_p;
  localparam int PW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int CW = $clog2(fifo_els_p + 1);

  localparam int FX_LSB   = X + Y;
  localparam int FY_LSB   = 2 * X + Y;
  localparam int DATA_LSB = 2 * (X + Y);
  localparam int ADDR_LSB = DATA_LSB + data_width_p;
  localparam int MASK_LSB = ADDR_LSB + addr_width_p;
  localparam int OP_LSB   = MASK_LSB + M;

  // Keeps only the in-tile offset of a remote address
  localparam logic [addr_width_p-1:0] ADDR_KEEP = {addr_width_p{1'b1}} >> (1 + X + Y);

  logic [P-1:0]    r_mem [fifo_els_p];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;
  logic [P-1:0]    w_head;
  logic [1:0]      w_op;
  logic            w_unused_dst;

  assign w_full  = (r_count == CW'(fifo_els_p));
  assign w_empty = (r_count == '0);

  // Both handshakes are masked while reset is held so nothing leaks through
  assign ready_o = reset_i & ~w_full;
  assign pkt_v_o = reset_i & ~w_empty;
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & pkt_v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)
        r_wr_ptr <= (r_wr_ptr == PW'(fifo_els_p - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_deq)
        r_rd_ptr <= (r_rd_ptr == PW'(fifo_els_p - 1)) ? '0 : r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq)
      r_mem[r_wr_ptr] <= data_i;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign w_op          = w_head[OP_LSB +: 2];
  assign store_mask_o  = w_head[MASK_LSB +: M];
  assign store_addr_o  = w_head[ADDR_LSB +: addr_width_p];
  assign store_data_o  = w_head[DATA_LSB +: data_width_p];
  assign from_y_cord_o = w_head[FY_LSB +: Y];
  assign from_x_cord_o = w_head[FX_LSB +: X];
  // Destination coordinates have already done their job in the mesh
  assign w_unused_dst  = ^w_head[X+Y-1:0];

  always_comb begin
    pkt_remote_store_o = 1'b0;
    pkt_freeze_o       = 1'b0;
    pkt_unfreeze_o     = 1'b0;
    pkt_unknown_o      = 1'b0;
    if (pkt_v_o) begin
      if (w_op == 2'b01)
        pkt_remote_store_o = 1'b1;
      else if ((w_op == 2'b10) && (store_addr_o == '0)) begin
        if (store_data_o[0])
          pkt_freeze_o = 1'b1;
        else
          pkt_unfreeze_o = 1'b1;
      end else
        pkt_unknown_o = 1'b1;
    end
  end

  logic                      w_remote;
  logic [Y-1:0]              w_dst_y;
  logic [X-1:0]              w_dst_x;
  logic [addr_width_p-1:0]   w_enc_addr;

  assign w_remote   = enc_addr_i[addr_width_p-1];
  assign w_dst_y    = enc_addr_i[addr_width_p-2 -: Y];
  assign w_dst_x    = enc_addr_i[addr_width_p-2-Y -: X];
  assign w_enc_addr = enc_addr_i & ADDR_KEEP;

  assign v_o              = enc_v_i & w_remote & enc_we_i;
  assign ret_store_cntr_o = enc_v_i & w_remote & ~enc_we_i;
  assign data_o = v_o ? {2'b01, enc_mask_i, w_enc_addr, enc_data_i,
                         my_y_i, my_x_i, w_dst_y, w_dst_x}
                      : '0;

endmodule

// File: tb/tb_manycore_endpoint_codec.sv
// Directed bench for manycore_endpoint_codec: FIFO ordering/flow control, head decode,
// store encoding and reset behaviour, each against hand-computed values.
module tb_manycore_endpoint_codec;

  localparam int P = 90;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic [P-1:0]  data_i;
  logic          ready_o;
  logic          yumi_i;
  logic          pkt_v_o;
  logic          pkt_remote_store_o;
  logic          pkt_freeze_o;
  logic          pkt_unfreeze_o;
  logic          pkt_unknown_o;
  logic [31:0]   store_data_o;
  logic [31:0]   store_addr_o;
  logic [3:0]    store_mask_o;
  logic [4:0]    from_x_cord_o;
  logic [4:0]    from_y_cord_o;
  logic          enc_v_i;
  logic          enc_we_i;
  logic [31:0]   enc_addr_i;
  logic [31:0]   enc_data_i;
  logic [3:0]    enc_mask_i;
  logic [4:0]    my_x_i;
  logic [4:0]    my_y_i;
  logic          v_o;
  logic [P-1:0]  data_o;
  logic          ret_store_cntr_o;

  int checks = 0;
  int errors = 0;

  manycore_endpoint_codec dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .yumi_i(yumi_i), .pkt_v_o(pkt_v_o), .pkt_remote_store_o(pkt_remote_store_o),
    .pkt_freeze_o(pkt_freeze_o), .pkt_unfreeze_o(pkt_unfreeze_o),
    .pkt_unknown_o(pkt_unknown_o), .store_data_o(store_data_o),
    .store_addr_o(store_addr_o), .store_mask_o(store_mask_o),
    .from_x_cord_o(from_x_cord_o), .from_y_cord_o(from_y_cord_o),
    .enc_v_i(enc_v_i), .enc_we_i(enc_we_i), .enc_addr_i(enc_addr_i),
    .enc_data_i(enc_data_i), .enc_mask_i(enc_mask_i), .my_x_i(my_x_i),
    .my_y_i(my_y_i), .v_o(v_o), .data_o(data_o), .ret_store_cntr_o(ret_store_cntr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] mk(input logic [1:0] op, input logic [3:0] mask,
                                      input logic [31:0] addr, input logic [31:0] data,
                                      input logic [4:0] fy, input logic [4:0] fx,
                                      input logic [4:0] y, input logic [4:0] x);
    return {op, mask, addr, data, fy, fx, y, x};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [P-1:0] p);
    v_i = 1'b1;
    data_i = p;
    tick();
    v_i = 1'b0;
  endtask

  task automatic deq;
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    tick();
    tick();
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    checks++;
    if (pkt_v_o !== 1'b0) begin errors++; $display("FAIL reset_pkt_v got=%b exp=0", pkt_v_o); end
    checks++;
    if ({pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o});
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ready_o); end
    tick();
    checks++;
    if (pkt_v_o !== 1'b0) begin errors++; $display("FAIL release_pkt_v got=%b exp=0", pkt_v_o); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1;
      data_i = mk(2'b01, 4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i), 5'd1, 5'd1, 5'd0, 5'd0);
      tick();
      if (i == 0) begin
        checks++;
        if (pkt_v_o !== 1'b1) begin errors++; $display("FAIL first_visible got=%b exp=1", pkt_v_o); end
      end
    end
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", ready_o); end
    enq(mk(2'b01, 4'hF, 32'h10, 32'hA000_0004, 5'd1, 5'd1, 5'd0, 5'd0));
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL full_hold_ready got=%b exp=0", ready_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pkt_v_o !== 1'b1 || store_data_o !== 32'hA000_0000 + 32'(i) || store_addr_o !== 32'(i * 4)) begin
        errors++;
        $display("FAIL drain_%0d got v=%b data=%h addr=%h exp v=1 data=%h addr=%h", i, pkt_v_o,
                 store_data_o, store_addr_o, 32'hA000_0000 + 32'(i), 32'(i * 4));
      end
      deq();
      if (i == 0) begin
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL unfull_ready got=%b exp=1", ready_o); end
      end
    end
    checks++;
    if (pkt_v_o !== 1'b0) begin errors++; $display("FAIL drained_pkt_v got=%b exp=0", pkt_v_o); end
    deq();
    enq(mk(2'b01, 4'h1, 32'h20, 32'h5555_AAAA, 5'd0, 5'd0, 5'd0, 5'd0));
    checks++;
    if (pkt_v_o !== 1'b1 || store_data_o !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL yumi_empty got v=%b data=%h exp v=1 data=5555aaaa", pkt_v_o, store_data_o);
    end
    deq();
    checks++;
    if (pkt_v_o !== 1'b0) begin errors++; $display("FAIL yumi_empty_drain got=%b exp=0", pkt_v_o); end
  endtask

  task automatic test_back_to_back;
    enq(mk(2'b01, 4'h1, 32'h0, 32'h0000_0A0A, 5'd0, 5'd0, 5'd0, 5'd0));
    v_i = 1'b1;
    yumi_i = 1'b1;
    data_i = mk(2'b01, 4'h2, 32'h0, 32'h0000_0B0B, 5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    v_i = 1'b0;
    yumi_i = 1'b0;
    checks++;
    if (pkt_v_o !== 1'b1 || store_data_o !== 32'h0000_0B0B) begin
      errors++;
      $display("FAIL b2b_head got v=%b data=%h exp v=1 data=00000b0b", pkt_v_o, store_data_o);
    end
    deq();
    checks++;
    if (pkt_v_o !== 1'b0) begin errors++; $display("FAIL b2b_count got=%b exp=0", pkt_v_o); end
  endtask

  task automatic test_decode;
    enq(mk(2'b01, 4'hF, 32'h40, 32'hDEAD_BEEF, 5'd2, 5'd3, 5'd0, 5'd0));
    checks++;
    if ({pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o} !== 4'b1000 ||
        store_addr_o !== 32'h40 || store_data_o !== 32'hDEAD_BEEF || store_mask_o !== 4'hF ||
        from_x_cord_o !== 5'd3 || from_y_cord_o !== 5'd2) begin
      errors++;
      $display("FAIL decode_store got flags=%b addr=%h data=%h mask=%h fx=%0d fy=%0d exp 1000 40 deadbeef f 3 2",
               {pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o},
               store_addr_o, store_data_o, store_mask_o, from_x_cord_o, from_y_cord_o);
    end
    deq();
    begin
      logic [1:0]  ops   [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b00};
      logic [31:0] addrs [5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
      logic [31:0] datas [5] = '{32'h1, 32'h0, 32'h1, 32'h1, 32'h1};
      logic [3:0]  exps  [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        enq(mk(ops[i], 4'h0, addrs[i], datas[i], 5'd0, 5'd0, 5'd0, 5'd0));
        checks++;
        if ({pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o} !== exps[i]) begin
          errors++;
          $display("FAIL decode_%0d got=%b exp=%b", i,
                   {pkt_remote_store_o, pkt_freeze_o, pkt_unfreeze_o, pkt_unknown_o}, exps[i]);
        end
        deq();
      end
    end
  endtask

  task automatic test_encode;
    enc_v_i = 1'b1; enc_we_i = 1'b1; enc_addr_i = 32'h8820_0100;
    enc_data_i = 32'h1234_5678; enc_mask_i = 4'hF; my_x_i = 5'd0; my_y_i = 5'd0;
    #1;
    checks++;
    if (v_o !== 1'b1 || ret_store_cntr_o !== 1'b0 ||
        data_o !== mk(2'b01, 4'hF, 32'h100, 32'h1234_5678, 5'd0, 5'd0, 5'd2, 5'd1)) begin
      errors++;
      $display("FAIL enc_write got v=%b ret=%b pkt=%h", v_o, ret_store_cntr_o, data_o);
    end
    enc_addr_i = 32'hFFDF_FFFF; enc_data_i = 32'hCAFE_F00D; enc_mask_i = 4'h3;
    my_x_i = 5'd7; my_y_i = 5'd9;
    #1;
    checks++;
    if (v_o !== 1'b1 ||
        data_o !== mk(2'b01, 4'h3, 32'h001F_FFFF, 32'hCAFE_F00D, 5'd9, 5'd7, 5'd31, 5'd30)) begin
      errors++;
      $display("FAIL enc_write_edge got v=%b pkt=%h", v_o, data_o);
    end
    enc_we_i = 1'b0; enc_addr_i = 32'h8820_0100;
    #1;
    checks++;
    if (v_o !== 1'b0 || ret_store_cntr_o !== 1'b1 || data_o !== '0) begin
      errors++;
      $display("FAIL enc_read got v=%b ret=%b pkt=%h exp v=0 ret=1 pkt=0", v_o, ret_store_cntr_o, data_o);
    end
    enc_addr_i = 32'h0820_0100;
    #1;
    checks++;
    if (v_o !== 1'b0 || ret_store_cntr_o !== 1'b0) begin
      errors++;
      $display("FAIL enc_local_read got v=%b ret=%b exp 0 0", v_o, ret_store_cntr_o);
    end
    enc_we_i = 1'b1;
    #1;
    checks++;
    if (v_o !== 1'b0 || ret_store_cntr_o !== 1'b0) begin
      errors++;
      $display("FAIL enc_local_write got v=%b ret=%b exp 0 0", v_o, ret_store_cntr_o);
    end
    enc_v_i = 1'b0; enc_addr_i = 32'h8820_0100;
    #1;
    checks++;
    if (v_o !== 1'b0 || ret_store_cntr_o !== 1'b0) begin
      errors++;
      $display("FAIL enc_idle got v=%b ret=%b exp 0 0", v_o, ret_store_cntr_o);
    end
  endtask

  task automatic test_mid_reset;
    enq(mk(2'b01, 4'h1, 32'h0, 32'h1111_1111, 5'd0, 5'd0, 5'd0, 5'd0));
    enq(mk(2'b01, 4'h1, 32'h0, 32'h2222_2222, 5'd0, 5'd0, 5'd0, 5'd0));
    checks++;
    if (pkt_v_o !== 1'b1) begin errors++; $display("FAIL mid_filled got=%b exp=1", pkt_v_o); end
    reset_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || pkt_v_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_during got ready=%b v=%b exp 0 0", ready_o, pkt_v_o);
    end
    tick();
    reset_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || pkt_v_o !== 1'b0 || pkt_remote_store_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got ready=%b v=%b rs=%b exp 1 0 0", ready_o, pkt_v_o, pkt_remote_store_o);
    end
    enq(mk(2'b01, 4'h1, 32'h0, 32'h3333_3333, 5'd0, 5'd0, 5'd0, 5'd0));
    checks++;
    if (pkt_v_o !== 1'b1 || store_data_o !== 32'h3333_3333) begin
      errors++;
      $display("FAIL mid_new_head got v=%b data=%h exp 1 33333333", pkt_v_o, store_data_o);
    end
    deq();
  endtask

  initial begin
    reset_i = 1'b0; v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    enc_v_i = 1'b0; enc_we_i = 1'b0; enc_addr_i = '0; enc_data_i = '0;
    enc_mask_i = '0; my_x_i = '0; my_y_i = '0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_decode();
    test_encode();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
